// File: rtl/regfile_mp.sv
// regfile_mp: parameterised multi-read-port integer register file with
// write-to-read bypass, per-register pending bits and a bulk-clear sequencer.

// One combinational read port: stored value/pending bit, optionally
// overridden by a same-cycle write to the same non-zero register.
module regfile_mp_rport #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int AW     = $clog2(NREGS),
    parameter int BYPASS = 1
) (
    input  logic [AW-1:0]                ra,
    input  logic [NREGS-1:0][XLEN-1:0]   mem,
    input  logic [NREGS-1:0]             pend,
    input  logic                         wr_live,
    input  logic [AW-1:0]                waddr,
    input  logic [XLEN-1:0]              wdata,
    output logic [XLEN-1:0]              rd,
    output logic                         rp
);
    logic hit;

    // Forward only writes that will actually commit this edge.
    always_comb begin
        hit = (BYPASS != 0) && wr_live && (waddr == ra) && (waddr != '0);
        rd  = hit ? wdata : mem[ra];
        rp  = hit ? 1'b0  : pend[ra];
    end
endmodule

module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int AW     = $clog2(NREGS),
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NRD*AW-1:0]    raddr,
    output logic [NRD*XLEN-1:0]  rdata,
    output logic [NRD-1:0]       rpend,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [XLEN-1:0]      wdata,
    input  logic                 alloc_en,
    input  logic [AW-1:0]        alloc_addr,
    input  logic                 clr_req,
    output logic                 clr_busy
);
    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    state_t                      state, state_nx;
    logic [AW-1:0]               cnt, cnt_nx;
    logic [NREGS-1:0][XLEN-1:0]  mem;
    logic [NREGS-1:0]            pend;
    logic                        idle, wr_ok, al_ok;

    assign idle  = (state == IDLE);
    assign wr_ok = idle && we && (waddr != '0);
    assign al_ok = idle && alloc_en && (alloc_addr != '0);

    // Clear sequencer state and sweep counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            clr_busy <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            clr_busy <= (state_nx == CLEAR);
        end
    end

    // Next state: sweep entries 1..NREGS-1, entry 0 is hard zero already.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nx = CLEAR;
                    cnt_nx   = AW'(1);
                end
            end
            CLEAR: begin
                if (cnt == LAST) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + AW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Storage: writeback in IDLE, zero sweep in CLEAR; entry 0 never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
        end else if (state == CLEAR) begin
            mem[cnt] <= '0;
        end else if (wr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    // Pending bits: alloc after write so a same-register producer wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else if (idle && clr_req) begin
            pend <= '0;
        end else begin
            if (wr_ok) pend[waddr]      <= 1'b0;
            if (al_ok) pend[alloc_addr] <= 1'b1;
        end
    end

    // Read ports.
    for (genvar i = 0; i < NRD; i++) begin : g_rd
        regfile_mp_rport #(
            .XLEN   (XLEN),
            .NREGS  (NREGS),
            .AW     (AW),
            .BYPASS (BYPASS)
        ) u_rport (
            .ra      (raddr[i*AW +: AW]),
            .mem     (mem),
            .pend    (pend),
            .wr_live (idle && we),
            .waddr   (waddr),
            .wdata   (wdata),
            .rd      (rdata[i*XLEN +: XLEN]),
            .rp      (rpend[i])
        );
    end
endmodule
